// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end constants: NOP encoding, major opcodes and the
// fetch FSM state encoding.
package riscv_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   localparam logic [6:0] OP_LOAD   = 7'b000_0011;
   localparam logic [6:0] OP_STORE  = 7'b010_0011;
   localparam logic [6:0] OP_RTYPE  = 7'b011_0011;
   localparam logic [6:0] OP_ITYPE  = 7'b001_0011;
   localparam logic [6:0] OP_BRANCH = 7'b110_0011;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DROP = 2'd2
   } fetch_state_t;

   // Opcode seen by decode: a bubble is presented as the canonical NOP.
   function automatic logic [6:0] dec_opcode(input logic [31:0] instr, input logic valid);
      return valid ? instr[6:0] : OP_ITYPE;
   endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/ack bus. Fetch drives the request side,
// memory answers with a one-cycle ack carrying the read data.
interface instr_fetch_unit_if #(
   parameter int XLEN = 32
);

   logic            IMemReq;
   logic [XLEN-1:0] IMemAddr;
   logic            IMemAck;
   logic [31:0]     IMemRdata;

   modport master (output IMemReq, IMemAddr, input IMemAck, IMemRdata);
   modport slave  (input IMemReq, IMemAddr, output IMemAck, IMemRdata);

endinterface

// File: rtl/instr_skid_buf.sv
// One-entry {instr, pc} holding slot for a word that returned while decode
// was stalled. Flush wins over push; push with pop replaces the entry.
module instr_skid_buf
   import riscv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_push,
   input  logic            i_pop,
   input  logic            i_flush,
   input  logic [31:0]     i_instr,
   input  logic [XLEN-1:0] i_pc,
   output logic            o_full,
   output logic [31:0]     o_instr,
   output logic [XLEN-1:0] o_pc
);

   logic            r_full;
   logic [31:0]     r_instr;
   logic [XLEN-1:0] r_pc;

   // Occupancy flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       r_full <= 1'b0;
      else if (i_flush) r_full <= 1'b0;
      else if (i_push)  r_full <= 1'b1;
      else if (i_pop)   r_full <= 1'b0;
   end

   // Payload capture on push.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_instr <= NOP_INSTR;
         r_pc    <= '0;
      end else if (i_push && !i_flush) begin
         r_instr <= i_instr;
         r_pc    <= i_pc;
      end
   end

   assign o_full  = r_full;
   assign o_instr = r_instr;
   assign o_pc    = r_pc;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns FetchPC, keeps one request outstanding to instruction
// memory, parks a returned word in the skid slot when decode stalls, and
// squashes wrong-path data on a redirect.
module instr_fetch_unit
   import riscv_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               PCSrc,
   input  logic [XLEN-1:0]    PCTarget,
   input  logic               Stall,
   instr_fetch_unit_if.master imem,
   output logic               InstrValid,
   output logic [31:0]        Instr,
   output logic [6:0]         Opcode,
   output logic [XLEN-1:0]    PC,
   output logic [XLEN-1:0]    PCPlus4
);

   fetch_state_t    r_state, w_state_nxt;
   logic [XLEN-1:0] r_fpc, r_addr, r_pc, w_fpc_nxt, w_skid_pc;
   logic [31:0]     r_instr, w_skid_instr;
   logic            r_valid;
   logic            w_req, w_ack_ok, w_free, w_pop, w_push;
   logic            w_skid_full, w_skid_full_nxt, w_wait;

   assign w_req    = (r_state != ST_IDLE);
   assign w_wait   = w_req && !imem.IMemAck;
   // Only an ack in REQ with no redirect delivers a usable word.
   assign w_ack_ok = (r_state == ST_REQ) && imem.IMemAck && !PCSrc;
   // Output slot can take a word if empty or being consumed this cycle.
   assign w_free   = !r_valid || !Stall;
   // Skid is older than any new ack, so it drains first to keep order.
   assign w_pop    = w_skid_full && w_free && !PCSrc;
   assign w_push   = w_ack_ok && (!w_free || w_skid_full);
   assign w_skid_full_nxt = w_push || (w_skid_full && !w_pop);

   assign w_fpc_nxt = PCSrc    ? (PCTarget & ~XLEN'(3)) :
                      w_ack_ok ? (r_fpc + XLEN'(4))     : r_fpc;

   instr_skid_buf #(.XLEN(XLEN)) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (PCSrc),
      .i_instr (imem.IMemRdata),
      .i_pc    (r_addr),
      .o_full  (w_skid_full),
      .o_instr (w_skid_instr),
      .o_pc    (w_skid_pc)
   );

   // Fetch FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next state: a redirect with a request still in flight must wait out its ack.
   always_comb begin
      w_state_nxt = r_state;
      if (PCSrc) begin
         w_state_nxt = w_wait ? ST_DROP : ST_REQ;
      end else begin
         case (r_state)
            ST_IDLE: w_state_nxt = w_skid_full_nxt ? ST_IDLE : ST_REQ;
            ST_REQ:  if (imem.IMemAck) w_state_nxt = w_skid_full_nxt ? ST_IDLE : ST_REQ;
            ST_DROP: if (imem.IMemAck) w_state_nxt = ST_REQ;
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // FetchPC and request address; the address is frozen while a request waits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fpc  <= RESET_PC;
         r_addr <= RESET_PC;
      end else begin
         r_fpc <= w_fpc_nxt;
         if (!w_wait) r_addr <= w_fpc_nxt;
      end
   end

   // Decode-facing output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_instr <= NOP_INSTR;
         r_pc    <= RESET_PC;
      end else if (PCSrc) begin
         r_valid <= 1'b0;
      end else if (w_pop) begin
         r_valid <= 1'b1;
         r_instr <= w_skid_instr;
         r_pc    <= w_skid_pc;
      end else if (w_ack_ok && w_free) begin
         r_valid <= 1'b1;
         r_instr <= imem.IMemRdata;
         r_pc    <= r_addr;
      end else if (r_valid && !Stall) begin
         r_valid <= 1'b0;
      end
   end

   assign imem.IMemReq  = w_req;
   assign imem.IMemAddr = r_addr;
   assign InstrValid    = r_valid;
   assign Instr         = r_instr;
   assign PC            = r_pc;
   assign PCPlus4       = r_pc + XLEN'(4);
   assign Opcode        = dec_opcode(r_instr, r_valid);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios with literal expectations,
// plus a per-cycle reference model of the delivered instruction stream.
module tb_instr_fetch_unit;
   import riscv_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n, rst1_n, PCSrc, Stall;
   logic [31:0] PCTarget;
   logic        v0, v1;
   logic [31:0] instr0, instr1, pc0, pc1, pcp0, pcp1;
   logic [6:0]  op0, op1;

   int          n_pass = 0, n_tot = 0, n_cons = 0, ack_dly = 0, wcnt = 0, n_snap;
   logic [31:0] exp_pc, p_addr, p_instr, p_pc;
   logic        p_req, p_ack, p_vld, p_stall, p_pcsrc;

   always #5 clk = ~clk;

   instr_fetch_unit_if #(.XLEN(32)) mif ();
   instr_fetch_unit_if #(.XLEN(32)) mif1 ();

   instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst_n(rst_n), .PCSrc(PCSrc), .PCTarget(PCTarget), .Stall(Stall),
      .imem(mif), .InstrValid(v0), .Instr(instr0), .Opcode(op0), .PC(pc0), .PCPlus4(pcp0));

   instr_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut1 (
      .clk(clk), .rst_n(rst1_n), .PCSrc(1'b0), .PCTarget(32'h0), .Stall(1'b0),
      .imem(mif1), .InstrValid(v1), .Instr(instr1), .Opcode(op1), .PC(pc1), .PCPlus4(pcp1));

   // Memory image: word index in the upper bits, opcode cycling through the set.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [6:0] op;
      case (a[4:2])
         3'd0, 3'd5: op = OP_LOAD;
         3'd1, 3'd6: op = OP_STORE;
         3'd2, 3'd7: op = OP_RTYPE;
         3'd3:       op = OP_ITYPE;
         default:    op = OP_BRANCH;
      endcase
      return {a[26:2], op};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", nm, act, exp);
   endtask

   // Reference model of dut, evaluated once per cycle at the falling edge.
   task automatic model();
      if (!rst_n) begin
         chk("rst_req", mif.IMemReq, 0);
         chk("rst_addr", mif.IMemAddr, 0);
         chk("rst_vld", v0, 0);
         chk("rst_instr", instr0, 32'h13);
         chk("rst_pc", pc0, 0);
         exp_pc = 0; p_req = 0; p_ack = 0; p_vld = 0; p_stall = 0; p_pcsrc = 0;
      end else begin
         chk("opcode", op0, v0 ? {25'd0, instr0[6:0]} : 32'h13);
         chk("pcplus4", pcp0, pc0 + 32'd4);
         if (v0) chk("instr_data", instr0, mem_word(pc0));
         if (p_req && !p_ack) begin
            chk("req_hold", mif.IMemReq, 1);
            chk("addr_hold", mif.IMemAddr, p_addr);
         end
         if (mif.IMemReq) chk("addr_align", mif.IMemAddr[1:0], 0);
         if (p_vld && p_stall && !p_pcsrc) begin
            chk("stall_vld", v0, 1);
            chk("stall_instr", instr0, p_instr);
            chk("stall_pc", pc0, p_pc);
         end
         if (PCSrc) exp_pc = PCTarget & ~32'h3;
         else if (v0 && !Stall) begin
            chk("pc_seq", pc0, exp_pc);
            exp_pc += 4;
            n_cons++;
         end
         p_req = mif.IMemReq; p_ack = mif.IMemAck; p_addr = mif.IMemAddr;
         p_vld = v0; p_stall = Stall; p_pcsrc = PCSrc; p_instr = instr0; p_pc = pc0;
      end
   endtask

   task automatic cyc(input logic st, input logic src, input logic [31:0] tgt);
      @(posedge clk); #1;
      Stall = st; PCSrc = src; PCTarget = tgt;
      @(negedge clk); model();
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 0; Stall = 0; PCSrc = 0; PCTarget = 0; ack_dly = 0;
      @(negedge clk); model();
      @(posedge clk); #1; rst_n = 1;
      @(negedge clk); model();
   endtask

   // Memory responders: dut acks after ack_dly waiting cycles, dut1 acks at once.
   initial begin
      mif.IMemAck = 0; mif.IMemRdata = 0; mif1.IMemAck = 0; mif1.IMemRdata = 0;
      forever begin
         @(posedge clk); #2;
         if (!rst_n || !mif.IMemReq) begin
            mif.IMemAck = 0; wcnt = 0;
         end else if (wcnt >= ack_dly) begin
            mif.IMemAck = 1; mif.IMemRdata = mem_word(mif.IMemAddr); wcnt = 0;
         end else begin
            mif.IMemAck = 0; wcnt++;
         end
         mif1.IMemAck   = rst1_n && mif1.IMemReq;
         mif1.IMemRdata = mem_word(mif1.IMemAddr);
      end
   end

   initial begin
      rst_n = 0; rst1_n = 0; Stall = 0; PCSrc = 0; PCTarget = 0;

      // Streaming fetch, ack every cycle.
      do_reset();
      chk("t1_idle_req", mif.IMemReq, 0);
      cyc(0, 0, 0);
      chk("t1_c1_req", mif.IMemReq, 1);  chk("t1_c1_addr", mif.IMemAddr, 32'h0);
      chk("t1_c1_vld", v0, 0);
      cyc(0, 0, 0);
      chk("t1_c2_addr", mif.IMemAddr, 32'h4); chk("t1_c2_vld", v0, 1);
      chk("t1_c2_pc", pc0, 32'h0);            chk("t1_c2_op", op0, OP_LOAD);
      cyc(0, 0, 0);
      chk("t1_c3_addr", mif.IMemAddr, 32'h8); chk("t1_c3_pc", pc0, 32'h4);
      chk("t1_c3_op", op0, OP_STORE);         chk("t1_c3_instr", instr0, 32'h0000_00A3);
      cyc(0, 0, 0);
      chk("t1_c4_addr", mif.IMemAddr, 32'hC); chk("t1_c4_instr", instr0, 32'h0000_0133);

      // Slow memory: second request waits three cycles.
      do_reset();
      cyc(0, 0, 0);
      ack_dly = 2;
      cyc(0, 0, 0);
      chk("t2_c2_addr", mif.IMemAddr, 32'h4); chk("t2_c2_pc", pc0, 32'h0);
      cyc(0, 0, 0);
      chk("t2_c3_req", mif.IMemReq, 1); chk("t2_c3_addr", mif.IMemAddr, 32'h4);
      chk("t2_c3_vld", v0, 0);
      cyc(0, 0, 0);
      chk("t2_c4_req", mif.IMemReq, 1); chk("t2_c4_addr", mif.IMemAddr, 32'h4);
      chk("t2_c4_vld", v0, 0);
      cyc(0, 0, 0);
      chk("t2_c5_vld", v0, 1); chk("t2_c5_pc", pc0, 32'h4);

      // Stall for four cycles: skid fills, request stops, order is kept.
      do_reset();
      cyc(0, 0, 0);
      n_snap = n_cons;
      cyc(1, 0, 0);
      chk("t3_c2_pc", pc0, 32'h0);
      cyc(1, 0, 0);
      chk("t3_c3_req", mif.IMemReq, 0);
      cyc(1, 0, 0);
      cyc(1, 0, 0);
      chk("t3_c5_pc", pc0, 32'h0);
      cyc(0, 0, 0);
      chk("t3_c6_req", mif.IMemReq, 0);
      cyc(0, 0, 0);
      chk("t3_c7_addr", mif.IMemAddr, 32'h8); chk("t3_c7_pc", pc0, 32'h4);
      cyc(0, 0, 0);
      cyc(0, 0, 0);
      chk("t3_c9_pc", pc0, 32'hC);
      chk("t3_count", n_cons - n_snap, 4);

      // Redirect while the request to 0x8 is still waiting.
      do_reset();
      cyc(0, 0, 0);
      cyc(0, 0, 0);
      ack_dly = 100;
      cyc(0, 0, 0);
      chk("t4_c3_addr", mif.IMemAddr, 32'h8); chk("t4_c3_ack", mif.IMemAck, 0);
      cyc(0, 1, 32'h100);
      ack_dly = 0;
      cyc(0, 0, 0);
      chk("t4_c5_req", mif.IMemReq, 1); chk("t4_c5_addr", mif.IMemAddr, 32'h8);
      chk("t4_c5_ack", mif.IMemAck, 1); chk("t4_c5_vld", v0, 0);
      cyc(0, 0, 0);
      chk("t4_c6_addr", mif.IMemAddr, 32'h100); chk("t4_c6_vld", v0, 0);
      cyc(0, 0, 0);
      chk("t4_c7_vld", v0, 1); chk("t4_c7_pc", pc0, 32'h100);

      // Redirect in the ack cycle, unaligned target.
      do_reset();
      cyc(0, 0, 0);
      cyc(0, 1, 32'h103);
      cyc(0, 0, 0);
      chk("t5_c3_addr", mif.IMemAddr, 32'h100); chk("t5_c3_vld", v0, 0);
      cyc(0, 0, 0);
      chk("t5_c4_pc", pc0, 32'h100); chk("t5_c4_instr", instr0, 32'h0000_2003);

      // Address wrap from the top of memory, then reset mid-request.
      @(posedge clk); #1; rst1_n = 1;
      @(negedge clk); model();
      chk("t6_c0_req", mif1.IMemReq, 0); chk("t6_c0_pcp4", pcp1, 32'h0);
      cyc(0, 0, 0);
      chk("t6_c1_addr", mif1.IMemAddr, 32'hFFFF_FFFC);
      cyc(0, 0, 0);
      chk("t6_c2_addr", mif1.IMemAddr, 32'h0);   chk("t6_c2_vld", v1, 1);
      chk("t6_c2_pc", pc1, 32'hFFFF_FFFC);       chk("t6_c2_pcp4", pcp1, 32'h0);
      cyc(0, 0, 0);
      chk("t6_c3_pc", pc1, 32'h0); chk("t6_c3_req", mif1.IMemReq, 1);
      @(posedge clk); #1; rst1_n = 0; #1;
      chk("t6_rst_req", mif1.IMemReq, 0);
      chk("t6_rst_addr", mif1.IMemAddr, 32'hFFFF_FFFC);
      chk("t6_rst_vld", v1, 0);
      chk("t6_rst_instr", instr1, 32'h13);
      chk("t6_rst_pc", pc1, 32'hFFFF_FFFC);
      chk("t6_rst_op", op1, 7'h13);
      @(negedge clk); model();

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
